// File: rtl/tns_sched_pkg.sv
// tns_sched_pkg: shared state type, TNS encoder constants and clog2 helper
package tns_sched_pkg;
  typedef enum logic {IDLE, XFER} state_e;
  localparam int TNS_DW = 11;
  localparam int TNS_DATA_LIMIT = 2048;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/tns_link_scheduler_if.sv
// tns_link_scheduler_if: per-requester valid/ready word bus toward the scheduler
interface tns_link_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW = 11
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] req_ready;
  modport master(output req_valid, req_data, req_last, input req_ready);
  modport slave(input req_valid, req_data, req_last, output req_ready);
endinterface

// File: rtl/tns_link_scheduler_rr_arbiter.sv
// rr_arbiter: first set request at or after ptr_i, searching upward modulo NREQ
module rr_arbiter import tns_sched_pkg::*; #(
  parameter int NREQ = 4,
  localparam int IW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   win_o,
  output logic            any_o
);
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % NREQ]) begin
        win_o = IW'((int'(ptr_i) + k) % NREQ);
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tns_link_scheduler.sv
// tns_link_scheduler: round-robin burst scheduler feeding one TNS encoder, advancing it only on real beats
module tns_link_scheduler import tns_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int DW = TNS_DW,
  parameter int CW = 4,
  parameter int DATA_LIMIT = TNS_DATA_LIMIT,
  localparam int IW = clog2(NREQ)
) (
  input  logic                 clock,
  input  logic                 rst_n,
  tns_link_scheduler_if.slave  req,
  input  logic [CW-1:0]        cfg_burst_max,
  input  logic [CW-1:0]        cfg_timeout,
  output logic [DW-1:0]        enc_data,
  output logic                 enc_en,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 err_range
);
  localparam logic [DW:0] LIM = DATA_LIMIT[DW:0];
  localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);
  state_e state_q;
  logic [IW-1:0] rr_q, grant_q, win;
  logic [CW:0] beat_q, bmax_q, beat_nx;
  logic [CW-1:0] stall_q, tmo_q, stall_nx;
  logic [DW-1:0] data_q, word;
  logic en_q, err_q, any, beat, bad, done;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i(req.req_valid),
    .ptr_i(rr_q),
    .win_o(win),
    .any_o(any)
  );
  assign word = req.req_data[int'(grant_q)*DW +: DW];
  assign beat = (state_q == XFER) && req.req_valid[grant_q];
  assign bad = {1'b0, word} >= LIM;
  assign beat_nx = beat_q + 1'b1;
  assign stall_nx = &stall_q ? stall_q : stall_q + 1'b1;
  // a beat always wins over a timeout in the same cycle
  assign done = beat ? (req.req_last[grant_q] || beat_nx == bmax_q) : (|tmo_q && stall_nx >= tmo_q);
  assign req.req_ready = busy ? NREQ'(1) << grant_q : '0;
  assign busy = state_q == XFER;
  assign enc_data = data_q;
  assign enc_en = en_q;
  assign err_range = err_q;
  assign grant_id = grant_q;
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= '0;
      grant_q <= '0;
      beat_q <= '0;
      stall_q <= '0;
      bmax_q <= '0;
      tmo_q <= '0;
      data_q <= '0;
      en_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      en_q <= beat;
      err_q <= beat && bad;
      if (beat) data_q <= bad ? '0 : word;
      if (state_q == IDLE) begin
        if (any) begin
          state_q <= XFER;
          grant_q <= win;
          beat_q <= '0;
          stall_q <= '0;
          bmax_q <= {~|cfg_burst_max, cfg_burst_max};
          tmo_q <= cfg_timeout;
        end
      end else begin
        beat_q <= beat ? beat_nx : beat_q;
        stall_q <= beat ? '0 : stall_nx;
        if (done) begin
          state_q <= IDLE;
          rr_q <= grant_q == LAST_ID ? '0 : grant_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tns_link_scheduler.sv
// tb_tns_link_scheduler: random traffic against a packet-queue reference model with a beat scoreboard
module tb_tns_link_scheduler;
  localparam int NREQ = 4, DW = 11, CW = 4, LIMIT = 1000;
  logic clock = 1'b0, rst_n = 1'b0;
  logic [CW-1:0] cfg_burst_max = '0, cfg_timeout = '0;
  logic [DW-1:0] enc_data;
  logic enc_en, busy, err_range;
  logic [1:0] grant_id;
  int tests = 0, fails = 0;
  logic [DW:0] pq[NREQ][$];
  logic [DW:0] exp_q[$];
  int m_busy, m_grant, m_rr, m_beat, m_stall, m_bmax, m_tmo, m_data;
  bit rand_cfg;
  tns_link_scheduler_if #(.NREQ(NREQ), .DW(DW)) rif();
  tns_link_scheduler #(.NREQ(NREQ), .DW(DW), .CW(CW), .DATA_LIMIT(LIMIT)) dut (
    .clock(clock),
    .rst_n(rst_n),
    .req(rif.slave),
    .cfg_burst_max(cfg_burst_max),
    .cfg_timeout(cfg_timeout),
    .enc_data(enc_data),
    .enc_en(enc_en),
    .grant_id(grant_id),
    .busy(busy),
    .err_range(err_range)
  );
  always #5 clock = ~clock;
  task automatic check(input string n, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", n, got, want);
    end
  endtask
  task automatic mreset();
    m_busy = 0; m_grant = 0; m_rr = 0; m_beat = 0; m_stall = 0; m_bmax = 0; m_tmo = 0; m_data = 0;
    exp_q.delete();
  endtask
  task automatic load(input int i, input int d, input bit l);
    pq[i].push_back({l, DW'(d)});
  endtask
  function automatic int pending();
    int p = m_busy;
    for (int i = 0; i < NREQ; i++) p += pq[i].size();
    return p;
  endfunction
  // one cycle: check registered outputs, drive new inputs, advance the packet-level model
  task automatic step(input int vp);
    logic [NREQ-1:0] v;
    logic [DW:0] w;
    bit found;
    @(negedge clock);
    check("busy", busy, m_busy);
    check("grant_id", grant_id, m_grant);
    check("req_ready", rif.req_ready, m_busy != 0 ? 1 << m_grant : 0);
    check("enc_data_hold", enc_data, m_data);
    if (rand_cfg) begin
      cfg_burst_max = CW'($urandom_range(0, 3));
      cfg_timeout = CW'($urandom_range(0, 4));
    end
    for (int i = 0; i < NREQ; i++) begin
      v[i] = pq[i].size() > 0 && $urandom_range(0, 99) < vp;
      if (pq[i].size() > 0) w = pq[i][0];
      else w = (DW+1)'($urandom);
      rif.req_valid[i] = v[i];
      rif.req_data[i*DW +: DW] = w[DW-1:0];
      rif.req_last[i] = w[DW];
    end
    if (m_busy == 0) begin
      found = 0;
      for (int k = 0; k < NREQ; k++)
        if (!found && v[(m_rr + k) % NREQ]) begin
          found = 1;
          m_grant = (m_rr + k) % NREQ;
        end
      if (found) begin
        m_busy = 1; m_beat = 0; m_stall = 0;
        m_bmax = cfg_burst_max == 0 ? 16 : int'(cfg_burst_max);
        m_tmo = int'(cfg_timeout);
      end
    end else if (v[m_grant]) begin
      w = pq[m_grant].pop_front();
      m_data = int'(w[DW-1:0]) >= LIMIT ? 0 : int'(w[DW-1:0]);
      exp_q.push_back({int'(w[DW-1:0]) >= LIMIT, DW'(m_data)});
      m_beat++;
      m_stall = 0;
      if (w[DW] || m_beat == m_bmax) begin
        m_busy = 0;
        m_rr = (m_grant + 1) % NREQ;
      end
    end else begin
      if (m_stall < 15) m_stall++;
      if (m_tmo != 0 && m_stall >= m_tmo) begin
        m_busy = 0;
        m_rr = (m_grant + 1) % NREQ;
      end
    end
  endtask
  initial begin
    logic [DW:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (enc_en) begin
        if (exp_q.size() == 0) check("unexpected_beat", enc_en, 0);
        else begin
          e = exp_q.pop_front();
          check("beat_data", enc_data, e[DW-1:0]);
          check("beat_err", err_range, e[DW]);
        end
      end else if (err_range) check("err_without_en", err_range, 0);
    end
  end
  initial begin
    int i;
    mreset();
    rand_cfg = 0;
    rif.req_valid = '0; rif.req_data = '0; rif.req_last = '0;
    repeat (3) @(negedge clock);
    check("rst_enc_en", enc_en, 0);
    check("rst_enc_data", enc_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", rif.req_ready, 0);
    check("rst_err", err_range, 0);
    rst_n = 1'b1;
    load(0, 5, 0); load(0, 100, 0); load(0, 2047, 1);
    repeat (8) step(100);
    for (int r = 0; r < NREQ; r++) load(r, 10 + r, 1);
    load(0, 20, 1);
    repeat (14) step(100);
    cfg_burst_max = 2;
    for (int n = 0; n < 5; n++) load(1, 200 + n, n == 4);
    load(2, 300, 1);
    repeat (14) step(100);
    cfg_burst_max = 0; cfg_timeout = 3;
    load(0, 7, 0); load(1, 8, 1);
    repeat (12) step(100);
    load(3, 1500, 1); load(3, 999, 1); load(3, 1000, 1);
    repeat (8) step(100);
    rand_cfg = 1;
    repeat (400) begin
      if ($urandom_range(0, 1) == 1) begin
        i = $urandom_range(0, NREQ - 1);
        if (pq[i].size() < 6) load(i, $urandom_range(0, 2047), $urandom_range(0, 2) == 0);
      end
      step(70);
    end
    rand_cfg = 0; cfg_burst_max = 0; cfg_timeout = 0;
    for (int n = 0; n < 4; n++) load(2, 400 + n, 0);
    for (int n = 0; n < 60 && !(m_busy != 0 && pq[m_grant].size() > 0); n++) step(100);
    @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    check("arst_enc_en", enc_en, 0);
    check("arst_enc_data", enc_data, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", rif.req_ready, 0);
    check("arst_grant", grant_id, 0);
    check("arst_err", err_range, 0);
    mreset();
    rif.req_valid = '0;
    @(negedge clock);
    rst_n = 1'b1;
    for (int r = 0; r < NREQ; r++) load(r, 50 + r, 1);
    repeat (10) step(100);
    rand_cfg = 1;
    repeat (200) begin
      if ($urandom_range(0, 1) == 1) begin
        i = $urandom_range(0, NREQ - 1);
        if (pq[i].size() < 6) load(i, $urandom_range(0, 2047), $urandom_range(0, 2) == 0);
      end
      step(70);
    end
    rand_cfg = 0; cfg_burst_max = 0; cfg_timeout = 2;
    for (int n = 0; n < 3000 && pending() > 0; n++) begin
      if (m_busy != 0 && pq[m_grant].size() == 0) load(m_grant, $urandom_range(0, 2047), 1);
      step(100);
    end
    check("drained", pending(), 0);
    repeat (3) step(100);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
